bdu_bit_streamer: RTL
=====================

Name: bdu_bit_streamer

Overview:
- Transmit side of the bit-serial distance interface.
- Holds one 3-D query point and accepts reference points over a valid/ready handshake.
- Streams each query/reference pair to a bit-serial distance unit MSB-first, interleaved x,y,z, driving the unit's code, which_bit and threshold inputs.
- Honours the unit's early-termination signal, captures the final distance, and returns a tagged result over a second valid/ready handshake.

Parameters:
B, 32, coordinate bit width per dimension; full stream length is 3*B cycles.
ID_W, 16, width of the reference-point tag.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
q_load  in  1  load query point; honoured only in IDLE
q_x, q_y, q_z  in  B each  query coordinates
ref_valid  in  1  reference point offered
ref_ready  out  1  streamer can accept a reference point
ref_x, ref_y, ref_z  in  B each  reference coordinates
ref_id  in  ID_W  reference tag
thr_in  in  2*B  kth-best dist^2, latched at reference accept
bdu_clr  out  1  clear pulse to the distance unit's accumulators
q_bit  out  1  query bit to the distance unit
r_bit  out  1  reference bit to the distance unit
code  out  2  01=x, 10=y, 11=z, 00=idle
which_bit  out  7  2*p, where p is the current bit position
threshold  out  2*B  latched thr_in
bdu_terminate  in  1  early-termination flag from the distance unit
bdu_dist  in  2*B  partial/final dist^2 from the distance unit
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_id  out  ID_W  tag of the finished pair
res_dist  out  2*B  final dist^2; 0 when pruned
res_pruned  out  1  pair terminated early
res_bits  out  8  number of STREAM cycles issued (3*B if not pruned)

Behaviour:
- Reset (sync): state=IDLE, q_loaded=0. All outputs 0, including ref_ready, res_valid, code, q_bit, r_bit, bdu_clr and threshold.
- Whenever code=00, q_bit=r_bit=0, so the distance unit's accumulators and partial distance hold.

State machine:
- IDLE:
  - ref_ready = q_loaded.
  - q_load latches q_x/y/z and sets q_loaded. A q_load in any other state is ignored.
  - If q_load and ref_valid arrive in the same cycle, the accept is evaluated against the old q_loaded and the new query takes effect for the next pair.
  - On ref_valid&&ref_ready, latch ref_x/y/z, ref_id and thr_in, then go to CLEAR.
- CLEAR (1 cycle): bdu_clr=1, code=00. Next: STREAM with p=B-1, dimension=x, bit counter=0.
- STREAM (up to 3*B cycles):
  - Drive q_bit=q_d[p], r_bit=ref_d[p], code for dimension d, which_bit=2*p, threshold held.
  - Order per bit position is x,y,z; after z, p decrements.
  - The bit counter increments every STREAM cycle.
  - If bdu_terminate=1 in any STREAM cycle: go to RESULT with res_pruned=1, res_dist=0, res_bits=counter including the current cycle. The bit driven in that cycle is treated as not consumed.
  - Otherwise, after the cycle with p=0 and dimension=z, go to DRAIN.
  - bdu_terminate outside STREAM is ignored.
- DRAIN (1 cycle): code=00. Capture bdu_dist into res_dist at the end of the cycle, with res_pruned=0 and res_bits=3*B. Next: RESULT.
- RESULT:
  - res_valid=1, result fields stable until res_valid&&res_ready.
  - Then go to IDLE; ref_ready can rise the next cycle.
  - No new reference is accepted while a result is pending; backpressure propagates to the ref port.

Timing and arithmetic:
- Unpruned latency: accept edge at cycle 0, CLEAR in cycle 1, STREAM in cycles 2..3B+1, DRAIN in cycle 3B+2, res_valid from cycle 3B+3.
- which_bit is 7 bits wide; maximum 2*(B-1)=62 at B=32. Requires B<=64.
- res_bits saturates by construction at 3*B <= 255, so B<=85; the B<=64 limit governs.

Other rules:
- The query persists across pairs until a new q_load in IDLE or a reset.
- A reset mid-stream drops the pair with no result and clears q_loaded. The host must reload the query.

Test Plan:
- B=32; q_load q=(5,0,0); ref=(2,0,0), id=0x0A; terminate held 0; bdu_dist model returns 9 -> first STREAM cycle code=01, which_bit=62; x bits at p=2..0 are q=1,0,1 and r=0,1,0; res_valid in cycle 99; res_id=0x0A, res_dist=9, res_pruned=0, res_bits=96.
- Bit order: q_x=0x80000000, all else 0 -> q_bit=1 only on the first STREAM cycle; code sequence 01,10,11 repeats 32 times; which_bit steps 62,62,62,60,...,0.
- Prune: assert bdu_terminate on the 10th STREAM cycle -> next cycle code=00, q_bit=r_bit=0; res_valid one cycle later; res_pruned=1, res_dist=0, res_bits=10.
- Backpressure: hold res_ready=0 for 5 cycles with ref_valid=1 -> res_valid and fields stable, ref_ready=0; a res_ready pulse completes the handshake and ref_ready=1 in the following cycle.
- Reset at STREAM cycle 40 -> next cycle all outputs 0, ref_ready=0 until a new q_load; then a fresh pair completes correctly.
- q_load asserted during STREAM with q_x=0xFFFFFFFF -> ignored; the current and next pair use the original query.

Source files
------------

// File: rtl/bdu_bit_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : bdu_bit_streamer
//  Purpose  : Transmit side of the bit-serial distance interface. Holds one
//             3-D query point, accepts reference points, streams each pair
//             MSB-first (x,y,z interleaved) to the distance unit, honours its
//             early-termination flag and returns a tagged result.
//  Revision : 1.0 - initial release
// ============================================================================
module bdu_bit_streamer #(
  parameter int B    = 32,
  parameter int ID_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_load_i,
  input  logic [B-1:0]    q_x_i,
  input  logic [B-1:0]    q_y_i,
  input  logic [B-1:0]    q_z_i,
  input  logic            ref_valid_i,
  output logic            ref_ready_o,
  input  logic [B-1:0]    ref_x_i,
  input  logic [B-1:0]    ref_y_i,
  input  logic [B-1:0]    ref_z_i,
  input  logic [ID_W-1:0] ref_id_i,
  input  logic [2*B-1:0]  thr_in_i,
  output logic            bdu_clr_o,
  output logic            q_bit_o,
  output logic            r_bit_o,
  output logic [1:0]      code_o,
  output logic [6:0]      which_bit_o,
  output logic [2*B-1:0]  threshold_o,
  input  logic            bdu_terminate_i,
  input  logic [2*B-1:0]  bdu_dist_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [ID_W-1:0] res_id_o,
  output logic [2*B-1:0]  res_dist_o,
  output logic            res_pruned_o,
  output logic [7:0]      res_bits_o
);

  localparam int             PW        = (B > 1) ? $clog2(B) : 1;
  localparam logic [PW-1:0]  P_TOP     = PW'(B - 1);
  localparam logic [7:0]     FULL_BITS = 8'(3 * B);
  localparam logic [1:0]     DIM_X     = 2'b01;
  localparam logic [1:0]     DIM_Z     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            q_loaded_q, q_loaded_d;
  // Host-visible query (reloadable in IDLE) and the copy frozen for the pair
  logic [B-1:0]    qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
  logic [B-1:0]    pqx_q, pqx_d, pqy_q, pqy_d, pqz_q, pqz_d;
  logic [B-1:0]    rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [2*B-1:0]  thr_q, thr_d;
  logic [PW-1:0]   p_q, p_d;
  logic [1:0]      dim_q, dim_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2*B-1:0]  rdist_q, rdist_d;
  logic            rpruned_q, rpruned_d;
  logic [7:0]      rbits_q, rbits_d;
  logic [B-1:0]    w_qsel, w_rsel;

  assign w_qsel = (dim_q == DIM_X) ? pqx_q : (dim_q == 2'b10) ? pqy_q : pqz_q;
  assign w_rsel = (dim_q == DIM_X) ? rx_q  : (dim_q == 2'b10) ? ry_q  : rz_q;

  assign threshold_o  = thr_q;
  assign res_valid_o  = (state_q == S_RESULT);
  assign res_id_o     = id_q;
  assign res_dist_o   = rdist_q;
  assign res_pruned_o = rpruned_q;
  assign res_bits_o   = rbits_q;

  // State and datapath registers, all cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      q_loaded_q <= 1'b0;
      qx_q <= '0;  qy_q <= '0;  qz_q <= '0;
      pqx_q <= '0; pqy_q <= '0; pqz_q <= '0;
      rx_q <= '0;  ry_q <= '0;  rz_q <= '0;
      id_q <= '0;  thr_q <= '0;
      p_q <= '0;   dim_q <= '0; cnt_q <= '0;
      rdist_q <= '0; rpruned_q <= 1'b0; rbits_q <= '0;
    end else begin
      state_q    <= state_d;
      q_loaded_q <= q_loaded_d;
      qx_q <= qx_d;   qy_q <= qy_d;   qz_q <= qz_d;
      pqx_q <= pqx_d; pqy_q <= pqy_d; pqz_q <= pqz_d;
      rx_q <= rx_d;   ry_q <= ry_d;   rz_q <= rz_d;
      id_q <= id_d;   thr_q <= thr_d;
      p_q <= p_d;     dim_q <= dim_d; cnt_q <= cnt_d;
      rdist_q <= rdist_d; rpruned_q <= rpruned_d; rbits_q <= rbits_d;
    end
  end

  // Next-state logic and per-state outputs; code=00 keeps both bits at 0
  always_comb begin
    state_d    = state_q;
    q_loaded_d = q_loaded_q;
    qx_d = qx_q;   qy_d = qy_q;   qz_d = qz_q;
    pqx_d = pqx_q; pqy_d = pqy_q; pqz_d = pqz_q;
    rx_d = rx_q;   ry_d = ry_q;   rz_d = rz_q;
    id_d = id_q;   thr_d = thr_q;
    p_d = p_q;     dim_d = dim_q; cnt_d = cnt_q;
    rdist_d = rdist_q; rpruned_d = rpruned_q; rbits_d = rbits_q;
    ref_ready_o = 1'b0;
    bdu_clr_o   = 1'b0;
    code_o      = 2'b00;
    q_bit_o     = 1'b0;
    r_bit_o     = 1'b0;
    which_bit_o = '0;
    case (state_q)
      S_IDLE: begin
        ref_ready_o = q_loaded_q;
        // Accept uses the query held before any same-cycle reload
        if (ref_valid_i && q_loaded_q) begin
          pqx_d = qx_q; pqy_d = qy_q; pqz_d = qz_q;
          rx_d = ref_x_i; ry_d = ref_y_i; rz_d = ref_z_i;
          id_d    = ref_id_i;
          thr_d   = thr_in_i;
          state_d = S_CLEAR;
        end
        if (q_load_i) begin
          qx_d = q_x_i; qy_d = q_y_i; qz_d = q_z_i;
          q_loaded_d = 1'b1;
        end
      end
      S_CLEAR: begin
        bdu_clr_o = 1'b1;
        p_d       = P_TOP;
        dim_d     = DIM_X;
        cnt_d     = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        code_o      = dim_q;
        q_bit_o     = w_qsel[p_q];
        r_bit_o     = w_rsel[p_q];
        which_bit_o = 7'({p_q, 1'b0});
        cnt_d       = cnt_q + 8'd1;
        if (bdu_terminate_i) begin
          rpruned_d = 1'b1;
          rdist_d   = '0;
          rbits_d   = cnt_q + 8'd1;
          state_d   = S_RESULT;
        end else if (dim_q == DIM_Z) begin
          dim_d = DIM_X;
          if (p_q == '0) state_d = S_DRAIN;
          else           p_d     = p_q - 1'b1;
        end else begin
          dim_d = dim_q + 2'b01;
        end
      end
      S_DRAIN: begin
        rdist_d   = bdu_dist_i;
        rpruned_d = 1'b0;
        rbits_d   = FULL_BITS;
        state_d   = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
